// File: rtl/seg_digit_scanner_if.sv
// Bus bundle between the digit scanner and its environment.
//   Write port : wr_en, wr_addr, wr_data, wr_dp
//   Control    : scan_en, lzb
//   Decoder    : data, latch, blank, decimal_out
//   Display    : digit_sel (one-hot common-cathode select)
// slave  : the scanner (consumes writes/control, drives the decoder side)
// master : the environment (drives writes/control, observes the decoder side)
interface seg_digit_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [3:0]        wr_data;
  logic              wr_dp;
  logic              scan_en;
  logic              lzb;
  logic [3:0]        data;
  logic              latch;
  logic              blank;
  logic              decimal_out;
  logic [DIGITS-1:0] digit_sel;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, scan_en, lzb,
    output data, latch, blank, decimal_out, digit_sel
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, scan_en, lzb,
    input  data, latch, blank, decimal_out, digit_sel
  );
endinterface

// File: rtl/seg_digit_scanner.sv
// Multiplexed display feeder for a hex-to-7-segment decoder.
// Holds DIGITS nibbles + decimal points, and cycles through them as
// BLANK (dark gap) -> LATCH (strobe nibble into decoder) -> SHOW (digit lit),
// with optional leading-zero blanking.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears store and outputs
//   bus   : seg_digit_scanner_if.slave (write port, control, decoder/display outputs)
module seg_digit_scanner #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PRESCALE     = 16,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic                clk,
  input logic                reset,
  seg_digit_scanner_if.slave bus
);

  localparam int unsigned AW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_SHOW  = 2'd3;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(DIGITS - 1);

  // Digit store
  logic [3:0] store_nib [DIGITS];
  logic       store_dp  [DIGITS];

  // Sequencer state
  logic [1:0]    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [AW-1:0] idx_q, idx_n;
  logic          sup_q, sup_n;

  // Registered outputs
  logic [3:0]        data_q, data_n;
  logic              dp_q, dp_n;
  logic              latch_q, latch_n;
  logic              blank_q, blank_n;
  logic [DIGITS-1:0] sel_q, sel_n;

  logic upper_zero;
  logic sup_c;

  // Next-state sequencing; dropping scan_en aborts to IDLE from anywhere
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    if ((state_q != S_IDLE) && !bus.scan_en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.scan_en) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            idx_n   = '0;
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_n = S_LATCH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        S_LATCH: begin
          state_n = S_SHOW;
          cnt_n   = '0;
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            idx_n   = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Leading-zero test for the digit about to be latched: it and every
  // more-significant nibble are zero. Decimal points are deliberately ignored.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if ((j >= 32'(idx_n)) && (store_nib[j] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    sup_c = bus.lzb && (idx_n != '0) && upper_zero;
  end

  // Output values for the state being entered; data/dp/suppress are captured
  // on entry to LATCH so a write during LATCH or SHOW waits for the next pass.
  always_comb begin
    data_n  = data_q;
    dp_n    = dp_q;
    sup_n   = sup_q;
    latch_n = 1'b0;
    blank_n = 1'b1;
    sel_n   = '0;
    case (state_n)
      S_LATCH: begin
        latch_n = 1'b1;
        data_n  = store_nib[idx_n];
        dp_n    = store_dp[idx_n];
        sup_n   = sup_c;
      end
      S_SHOW: begin
        blank_n = sup_q;
        sel_n   = DIGITS'(1) << idx_n;
      end
      default: begin
      end
    endcase
  end

  // State, output and store registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sup_q   <= 1'b0;
      data_q  <= 4'h0;
      dp_q    <= 1'b0;
      latch_q <= 1'b0;
      blank_q <= 1'b1;
      sel_q   <= '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        store_nib[i] <= 4'h0;
        store_dp[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sup_q   <= sup_n;
      data_q  <= data_n;
      dp_q    <= dp_n;
      latch_q <= latch_n;
      blank_q <= blank_n;
      sel_q   <= sel_n;
      // Addresses past the last digit are dropped
      if (bus.wr_en && (32'(bus.wr_addr) < DIGITS)) begin
        store_nib[bus.wr_addr] <= bus.wr_data;
        store_dp[bus.wr_addr]  <= bus.wr_dp;
      end
    end
  end

  assign bus.data        = data_q;
  assign bus.decimal_out = dp_q;
  assign bus.latch       = latch_q;
  assign bus.blank       = blank_q;
  assign bus.digit_sel   = sel_q;

endmodule
